cpu_core: RTL



---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_core_if.sv | 19 +
 rtl/cpu_alu.sv | 32 +++
 rtl/cpu_core.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the accumulator CPU: the opcode encoding, the
// sequencer state encoding and helpers giving the two memory-mapped I/O
// addresses (display register and switch port) for an A-bit address field.
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_XOR   = 3'd4,
        OP_BNZ   = 3'd5,
        OP_JMP   = 3'd6,
        OP_HALT  = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Second-to-last word of the address space is the display register.
    function automatic int unsigned disp_addr(input int unsigned a);
        return (32'd1 << a) - 32'd2;
    endfunction

    // Last word of the address space reads the switch port.
    function automatic int unsigned switch_addr(input int unsigned a);
        return (32'd1 << a) - 32'd1;
    endfunction

endpackage

// File: rtl/cpu_core_if.sv
// ---------------------------------------------------------------------------
// cpu_core_if
// Program-load bus into the CPU's instruction/data memory.
//   prog_we   : write strobe (the core only honours it while stopped)
//   prog_addr : word address, A bits
//   prog_data : word to write, WORD_W bits
// master drives the bus (loader / testbench), slave is the core.
// ---------------------------------------------------------------------------
interface cpu_core_if #(
    parameter int WORD_W = 8,
    parameter int A      = 5
);
    logic              prog_we;
    logic [A-1:0]      prog_addr;
    logic [WORD_W-1:0] prog_data;

    modport master (output prog_we, output prog_addr, output prog_data);
    modport slave  (input  prog_we, input  prog_addr, input  prog_data);
endinterface

// File: rtl/cpu_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu
// Combinational accumulator datapath for LOAD/ADD/SUB/XOR.
//   acc     : current accumulator
//   operand : word read from memory or the switch port
//   opcode  : decoded opcode
//   result  : new accumulator value (acc unchanged for other opcodes)
// Arithmetic wraps modulo 2**WORD_W; no carry/borrow is kept.
// ---------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic [WORD_W-1:0] acc,
    input  logic [WORD_W-1:0] operand,
    input  opcode_t           opcode,
    output logic [WORD_W-1:0] result
);

    always_comb begin
        result = acc;
        case (opcode)
            OP_LOAD: result = operand;
            OP_ADD:  result = acc + operand;
            OP_SUB:  result = acc - operand;
            OP_XOR:  result = acc ^ operand;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// ---------------------------------------------------------------------------
// cpu_core
// Tiny accumulator CPU. Every instruction takes a FETCH and an EXEC cycle.
// Instruction word = {opcode, addr}; the top two addresses are I/O:
// 2**A-2 is the display register (write-only), 2**A-1 the switch port
// (read-only). Memory is loaded through the program bus while stopped.
//   clock     : rising-edge clock
//   n_reset   : asynchronous active-low reset (memory is not cleared)
//   run       : 1 = execute, 0 = stop and allow program load
//   prog      : program-load bus (slave side)
//   switches  : input port
//   disp      : display register
//   acc       : accumulator
//   pc        : program counter
//   busy      : high in FETCH or EXEC
//   halted    : high after a HALT until run drops
// WORD_W must be at least OP_W+2 and OP_W at least 3.
// ---------------------------------------------------------------------------
module cpu_core
    import cpu_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                       clock,
    input  logic                       n_reset,
    input  logic                       run,
    cpu_core_if.slave                  prog,
    input  logic [WORD_W-1:0]          switches,
    output logic [WORD_W-1:0]          disp,
    output logic [WORD_W-1:0]          acc,
    output logic [WORD_W-OP_W-1:0]     pc,
    output logic                       busy,
    output logic                       halted
);

    localparam int A     = WORD_W - OP_W;
    localparam int DEPTH = 2 ** A;
    localparam logic [A-1:0] DISP_ADDR = A'(disp_addr(A));
    localparam logic [A-1:0] SW_ADDR   = A'(switch_addr(A));

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] ir;
    state_t            state;

    logic [OP_W-1:0]   ir_op;
    logic [A-1:0]      ir_addr;
    opcode_t           opc;
    logic              op_nop;
    logic [WORD_W-1:0] operand;
    logic [WORD_W-1:0] alu_result;

    assign ir_op   = ir[WORD_W-1 -: OP_W];
    assign ir_addr = ir[A-1:0];
    assign opc     = opcode_t'(ir_op[2:0]);

    // Opcodes beyond the eight defined ones only exist with a wider field;
    // they execute as NOPs.
    if (OP_W > 3) begin : g_wide_op
        assign op_nop = |ir_op[OP_W-1:3];
    end else begin : g_narrow_op
        assign op_nop = 1'b0;
    end

    assign operand = (ir_addr == SW_ADDR) ? switches : mem[ir_addr];

    cpu_alu #(.WORD_W(WORD_W)) u_alu (
        .acc     (acc),
        .operand (operand),
        .opcode  (opc),
        .result  (alu_result)
    );

    // Memory has no reset so a loaded program survives n_reset. Loading is
    // only possible while stopped; program STOREs skip both I/O addresses.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && prog.prog_we) begin
            mem[prog.prog_addr] <= prog.prog_data;
        end else if (state == S_EXEC && !op_nop && opc == OP_STORE &&
                     ir_addr != DISP_ADDR && ir_addr != SW_ADDR) begin
            mem[ir_addr] <= acc;
        end
    end

    // Sequencer and architectural registers. busy/halted are registered
    // alongside the state so they change on the same edge as the state.
    // Leaving EXEC with run low clears pc last, overriding any jump.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            disp   <= '0;
            busy   <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir    <= mem[pc];
                    pc    <= pc + 1'b1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!op_nop) begin
                        case (opc)
                            OP_LOAD, OP_ADD, OP_SUB, OP_XOR: acc <= alu_result;
                            OP_STORE: if (ir_addr == DISP_ADDR) disp <= acc;
                            OP_BNZ:   if (acc != '0) pc <= ir_addr;
                            OP_JMP:   pc <= ir_addr;
                            default: ;
                        endcase
                    end
                    if (!op_nop && opc == OP_HALT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (!run) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        pc    <= '0;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state  <= S_IDLE;
                        halted <= 1'b0;
                        pc     <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
